csr_timer: RTL and testbench

Programmable 32-bit timer peripheral on the CSR bus, sitting downstream of the CSR bridge next to the GPIO block and upstream of the LM32 `interrupt` vector. It decodes its own CSR bank, counts prescaled clock ticks up to a compare value, and raises a level interrupt on match. It supports one-shot and auto-reload modes.

---
 rtl/csr_timer_pkg.sv | 26 ++
 rtl/timer_prescaler.sv | 27 ++
 rtl/csr_timer.sv | 136 +++++++++++++
 tb/tb_csr_timer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/csr_timer_pkg.sv
// csr_timer shared definitions
// register indices, CTRL/STATUS bit positions
package csr_timer_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_COMPARE  = 3'd1;
  localparam logic [2:0] REG_COUNTER  = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AR   = 1;
  localparam int CTRL_IE   = 2;
  localparam int STAT_PEND = 0;

  typedef struct packed {
    logic ie;
    logic ar;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_rd(ctrl_t c);
    return {29'd0, c};
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// csr_timer prescaler
// emits one tick every div+1 cycles while enabled
module timer_prescaler (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] r_pcnt;

  assign tick = en && (r_pcnt == div);

  // divider count, held at 0 while disabled or cleared
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pcnt <= '0;
    end else if (!en || clr || tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 16'd1;
    end
  end

endmodule

// File: rtl/csr_timer.sv
// csr_timer top: CSR decode, registers,
// counter/compare datapath and read mux
module csr_timer
  import csr_timer_pkg::*;
#(
  parameter logic [3:0] csr_addr = 4'h2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq
);

  ctrl_t       r_ctrl;
  logic [31:0] r_compare;
  logic [31:0] r_counter;
  logic [15:0] r_prescale;
  logic        r_pend;
  logic [31:0] r_do;

  logic        w_sel;
  logic [2:0]  w_idx;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_cmp;
  logic        w_wr_cnt;
  logic        w_wr_stat;
  logic        w_wr_psc;
  logic        w_tick;
  logic        w_eq;
  logic        w_hit;
  logic        w_step;
  logic [31:0] w_rd;
  logic        w_unused;

  assign w_sel     = (csr_a[13:10] == csr_addr);
  assign w_idx     = csr_a[2:0];
  assign w_wr      = csr_we && w_sel;
  assign w_wr_ctrl = w_wr && (w_idx == REG_CTRL);
  assign w_wr_cmp  = w_wr && (w_idx == REG_COMPARE);
  assign w_wr_cnt  = w_wr && (w_idx == REG_COUNTER);
  assign w_wr_stat = w_wr && (w_idx == REG_STATUS);
  assign w_wr_psc  = w_wr && (w_idx == REG_PRESCALE);
  assign w_unused  = ^csr_a[9:3];

  // a COUNTER write in a tick cycle swallows that tick
  assign w_eq   = (r_counter == r_compare);
  assign w_hit  = w_tick && !w_wr_cnt && w_eq;
  assign w_step = w_tick && !w_wr_cnt && !w_eq;

  timer_prescaler u_psc (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (r_ctrl.en),
    .clr     (w_wr_cnt),
    .div     (r_prescale),
    .tick    (w_tick)
  );

  // CTRL: CSR write wins over the one-shot EN clear
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_ctrl <= '0;
    end else if (w_wr_ctrl) begin
      r_ctrl.en <= csr_di[CTRL_EN];
      r_ctrl.ar <= csr_di[CTRL_AR];
      r_ctrl.ie <= csr_di[CTRL_IE];
    end else if (w_hit && !r_ctrl.ar) begin
      r_ctrl.en <= 1'b0;
    end
  end

  // COMPARE and PRESCALE are plain R/W registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_compare  <= '0;
      r_prescale <= '0;
    end else begin
      if (w_wr_cmp) r_compare  <= csr_di;
      if (w_wr_psc) r_prescale <= csr_di[15:0];
    end
  end

  // COUNTER: load, reload on match, or step on tick
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_counter <= '0;
    end else if (w_wr_cnt) begin
      r_counter <= csr_di;
    end else if (w_hit && r_ctrl.ar) begin
      r_counter <= '0;
    end else if (w_step) begin
      r_counter <= r_counter + 32'd1;
    end
  end

  // PEND: a new match beats a same-cycle W1C
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pend <= 1'b0;
    end else if (w_hit) begin
      r_pend <= 1'b1;
    end else if (w_wr_stat && csr_di[STAT_PEND]) begin
      r_pend <= 1'b0;
    end
  end

  // read data selection for the addressed register
  always_comb begin
    w_rd = '0;
    case (w_idx)
      REG_CTRL:     w_rd = ctrl_rd(r_ctrl);
      REG_COMPARE:  w_rd = r_compare;
      REG_COUNTER:  w_rd = r_counter;
      REG_STATUS:   w_rd = {31'd0, r_pend};
      REG_PRESCALE: w_rd = {16'd0, r_prescale};
      default:      w_rd = '0;
    endcase
  end

  // one-cycle registered read port, 0 off-bank
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_do <= '0;
    end else begin
      r_do <= w_sel ? w_rd : 32'd0;
    end
  end

  assign csr_do = r_do;
  assign irq    = r_pend && r_ctrl.ie;

endmodule

// File: tb/tb_csr_timer.sv
// csr_timer bench: reads are scoreboarded,
// irq is checked at fixed cycle offsets
module tb_csr_timer;

  localparam logic [3:0] BANK = 4'h2;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [13:0] csr_a   = '0;
  logic        csr_we  = 1'b0;
  logic [31:0] csr_di  = '0;
  logic [31:0] csr_do;
  logic        irq;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;
  bit  rd_issue = 1'b0;
  bit  rd_pend  = 1'b0;

  always #5 sys_clk = ~sys_clk;

  csr_timer #(.csr_addr(BANK)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .csr_a   (csr_a),
    .csr_we  (csr_we),
    .csr_di  (csr_di),
    .csr_do  (csr_do),
    .irq     (irq)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  always @(posedge sys_clk) rd_pend <= rd_issue;

  always @(negedge sys_clk) begin : mon
    sb_t e;
    if (rd_pend && sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, csr_do, e.exp);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wr(input logic [2:0] i, input logic [31:0] d);
    csr_a    = {BANK, 7'd0, i};
    csr_di   = d;
    csr_we   = 1'b1;
    rd_issue = 1'b0;
    @(negedge sys_clk);
    csr_we   = 1'b0;
  endtask

  task automatic rd_b(input logic [3:0] b, input logic [2:0] i,
                      input logic [31:0] e, input string tag);
    sb_t s;
    s.tag    = tag;
    s.exp    = e;
    csr_a    = {b, 7'h55, i};
    csr_we   = 1'b0;
    rd_issue = 1'b1;
    sb.push_back(s);
    @(negedge sys_clk);
    rd_issue = 1'b0;
  endtask

  task automatic rd(input logic [2:0] i, input logic [31:0] e,
                    input string tag);
    rd_b(BANK, i, e, tag);
  endtask

  initial begin
    // reset state
    idle(3);
    chk("rst_do", csr_do, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    sys_rst = 1'b0;
    for (int i = 0; i < 8; i++)
      rd(i[2:0], 32'd0, $sformatf("rst_reg%0d", i));
    rd_b(4'h3, 3'd1, 32'd0, "other_bank");

    // one-shot: PEND six edges after EN write
    wr(3'd1, 32'd5);
    wr(3'd4, 32'd0);
    wr(3'd0, 32'd5);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("os_irq_lo%0d", k), {31'd0, irq}, 32'd0);
      idle(1);
    end
    chk("os_irq_hi", {31'd0, irq}, 32'd1);
    rd(3'd0, 32'd4, "os_ctrl");
    rd(3'd2, 32'd5, "os_cnt");
    rd(3'd3, 32'd1, "os_pend");
    chk("os_irq_hold", {31'd0, irq}, 32'd1);
    wr(3'd3, 32'd1);
    chk("os_irq_w1c", {31'd0, irq}, 32'd0);

    // auto-reload: COMPARE=2, PRESCALE=3, IE=0
    wr(3'd0, 32'd0);
    wr(3'd2, 32'd0);
    wr(3'd1, 32'd2);
    wr(3'd4, 32'hFFFF_0003);
    rd(3'd4, 32'd3, "psc_mask");
    wr(3'd0, 32'hFFFF_FFFB);
    for (int k = 0; k < 16; k++) begin
      if (k == 5)
        rd(3'd0, 32'd3, "ar_ctrl");
      else if (k == 11 || k == 12)
        rd(3'd3, (k >= 12) ? 32'd1 : 32'd0,
           $sformatf("ar_pend%0d", k));
      else
        rd(3'd2, (k / 4) % 3, $sformatf("ar_cnt%0d", k));
      chk($sformatf("ar_irq%0d", k), {31'd0, irq}, 32'd0);
    end
    wr(3'd3, 32'd1);
    for (int t = 17; t <= 25; t++)
      rd(3'd3, (t >= 24) ? 32'd1 : 32'd0,
         $sformatf("ar_pend_t%0d", t));

    // W1C in the same cycle as a match
    idle(9);
    wr(3'd3, 32'd1);
    rd(3'd3, 32'd1, "w1c_vs_set");
    rd(3'd2, 32'd0, "w1c_cnt");

    // COUNTER write in the same cycle as a matching tick
    wr(3'd3, 32'd1);
    idle(8);
    wr(3'd2, 32'h100);
    rd(3'd2, 32'h100, "ld_vs_tick");
    rd(3'd3, 32'd0, "ld_no_pend");

    // freeze at 0x10 and resume
    wr(3'd0, 32'd0);
    wr(3'd2, 32'h0E);
    wr(3'd1, 32'h1000);
    wr(3'd0, 32'd1);
    idle(8);
    wr(3'd0, 32'd0);
    idle(50);
    rd(3'd2, 32'h10, "frz_cnt");
    wr(3'd0, 32'd1);
    for (int t = 0; t < 6; t++)
      rd(3'd2, (t >= 4) ? 32'h11 : 32'h10,
         $sformatf("resume%0d", t));

    // reset while PEND=1 and COUNTER=0x20
    wr(3'd0, 32'd0);
    wr(3'd2, 32'h1E);
    wr(3'd1, 32'h20);
    wr(3'd4, 32'd0);
    wr(3'd3, 32'd1);
    wr(3'd0, 32'd5);
    idle(3);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    rd(3'd3, 32'd1, "pre_rst_pend");
    rd(3'd2, 32'h20, "pre_rst_cnt");
    rd(3'd0, 32'd4, "pre_rst_ctrl");
    sys_rst = 1'b1;
    idle(1);
    sys_rst = 1'b0;
    chk("post_rst_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 5; i++)
      rd(i[2:0], 32'd0, $sformatf("post_rst%0d", i));

    idle(3);
    chk("sb_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
